// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle restoring divider producing quotient and remainder of X / Y,
//   one quotient bit per clock. Operands are captured when start is accepted
//   in IDLE; a one-cycle done pulse marks valid results, which are then held
//   until the next operation completes.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   start      request, only looked at in IDLE
//   X, Y       dividend / divisor, captured on an accepted start
//   busy       high while the iteration is running
//   done       one-cycle completion pulse
//   Q, R       quotient / remainder
//   DivByZero  captured divisor was zero
//   Overflow   signed overflow (most-negative / -1)
//
// Configuration
//   SIGNED_DIV_EN  when defined, X and Y are two's complement; magnitudes are
//                  divided and signs applied at the final load. When undefined
//                  the divider is unsigned and Overflow is tied to 0.
module seq_divider #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DivByZero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic [WIDTH-1:0] w_magX;
  logic [WIDTH-1:0] w_magY;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_bit;
  logic [WIDTH:0]   w_remNext;
  logic [WIDTH-1:0] w_quoNext;
  logic [WIDTH-1:0] w_qRes;
  logic [WIDTH-1:0] w_rRes;
  logic             w_lastStep;

`ifdef SIGNED_DIV_EN
  logic r_negQ;
  logic r_negR;
  logic r_ovfPend;
  logic r_ovf;

  // Divide magnitudes; the most-negative value maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit magnitude.
  assign w_magX = X[WIDTH-1] ? (~X + 1'b1) : X;
  assign w_magY = Y[WIDTH-1] ? (~Y + 1'b1) : Y;
  // Quotient truncates toward zero, remainder follows the dividend's sign.
  assign w_qRes = r_negQ ? (~w_quoNext + 1'b1) : w_quoNext;
  assign w_rRes = r_negR ? (~w_remNext[WIDTH-1:0] + 1'b1) : w_remNext[WIDTH-1:0];
  assign Overflow = r_ovf;
`else
  assign w_magX   = X;
  assign w_magY   = Y;
  assign w_qRes   = w_quoNext;
  assign w_rRes   = w_remNext[WIDTH-1:0];
  assign Overflow = 1'b0;
`endif

  // One restoring step: shift the next dividend bit into the remainder and
  // keep the subtraction only if it did not borrow (sign bit of trial clear).
  assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_div};
  assign w_bit      = ~w_trial[WIDTH];
  assign w_remNext  = w_bit ? w_trial : w_shift;
  assign w_quoNext  = {r_quo[WIDTH-2:0], w_bit};
  assign w_lastStep = (r_count == CW'(1));

  assign Q         = r_q;
  assign R         = r_r;
  assign DivByZero = r_dbz;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and status outputs.
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (Y == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_lastStep) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and the final result load. The
  // result registers are only written when an operation completes, so they
  // hold their values through IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_ovfPend <= 1'b0;
      r_ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (Y == '0) begin
              r_q   <= '1;
              r_r   <= X;
              r_dbz <= 1'b1;
`ifdef SIGNED_DIV_EN
              r_ovf <= 1'b0;
`endif
            end else begin
              r_rem   <= '0;
              r_quo   <= w_magX;
              r_div   <= w_magY;
              r_count <= CW'(WIDTH);
`ifdef SIGNED_DIV_EN
              r_negQ    <= X[WIDTH-1] ^ Y[WIDTH-1];
              r_negR    <= X[WIDTH-1];
              r_ovfPend <= (X == {1'b1, {(WIDTH-1){1'b0}}}) && (Y == '1);
`endif
            end
          end
        end
        S_RUN: begin
          r_rem   <= w_remNext;
          r_quo   <= w_quoNext;
          r_count <= r_count - 1'b1;
          if (w_lastStep) begin
            r_q   <= w_qRes;
            r_r   <= w_rRes;
            r_dbz <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_ovf <= r_ovfPend;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH=5). Expected results are pushed
//   to a scoreboard queue when a request is driven and compared when done
//   pulses. Honours SIGNED_DIV_EN for the expected values.
module tb_seq_divider;

  localparam int W = 5;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         busy;
  logic         done;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         DivByZero;
  logic         Overflow;

  int   errors = 0;
  int   checks = 0;
  vec_t sb[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .X(X),
    .Y(Y),
    .busy(busy),
    .done(done),
    .Q(Q),
    .R(R),
    .DivByZero(DivByZero),
    .Overflow(Overflow)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedDone: got done=1 expected no pending request");
      end else begin
        vec_t e;
        e = sb.pop_front();
        checkOutput("Q", int'(Q), int'(e.q));
        checkOutput("R", int'(R), int'(e.r));
        checkOutput("DivByZero", int'(DivByZero), int'(e.dbz));
        checkOutput("Overflow", int'(Overflow), int'(e.ovf));
      end
    end
  end

  // Wait for done, bounded; returns the number of negedges after the start
  // edge (0 on timeout) and how many of those had busy high.
  task automatic waitDone(output int lat, output int nBusy);
    lat   = 0;
    nBusy = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      @(negedge clk);
      if (busy) nBusy++;
      if (done) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneTimeout: got no done expected done within %0d cycles", 3 * W);
      sb.delete();
    end
  endtask

  // One complete operation with latency, busy-length and hold checks.
  task automatic applyStimulus(input vec_t v);
    int lat;
    int nBusy;
    @(negedge clk);
    X     = v.x;
    Y     = v.y;
    start = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(lat, nBusy);
    if (lat != 0) begin
      checkOutput("latency", lat, v.dbz ? 1 : W + 1);
      checkOutput("busyCycles", nBusy, v.dbz ? 0 : W);
      @(negedge clk);
      checkOutput("donePulseEnd", int'(done), 0);
      checkOutput("holdQ", int'(Q), int'(v.q));
      checkOutput("holdR", int'(R), int'(v.r));
    end
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   lat;
    int   nBusy;
    int   stray;

`ifdef SIGNED_DIV_EN
    vecs.push_back('{5'd19, 5'd4,  5'd29, 5'd31, 1'b0, 1'b0});
    vecs.push_back('{5'd16, 5'd31, 5'd16, 5'd0,  1'b0, 1'b1});
    vecs.push_back('{5'd7,  5'd30, 5'd29, 5'd1,  1'b0, 1'b0});
    vecs.push_back('{5'd25, 5'd2,  5'd29, 5'd31, 1'b0, 1'b0});
    vecs.push_back('{5'd7,  5'd0,  5'd31, 5'd7,  1'b1, 1'b0});
    vecs.push_back('{5'd16, 5'd1,  5'd16, 5'd0,  1'b0, 1'b0});
    vecs.push_back('{5'd15, 5'd16, 5'd0,  5'd15, 1'b0, 1'b0});
    vecs.push_back('{5'd23, 5'd5,  5'd31, 5'd28, 1'b0, 1'b0});
`else
    vecs.push_back('{5'd23, 5'd5,  5'd4,  5'd3,  1'b0, 1'b0});
    vecs.push_back('{5'd7,  5'd0,  5'd31, 5'd7,  1'b1, 1'b0});
    vecs.push_back('{5'd0,  5'd7,  5'd0,  5'd0,  1'b0, 1'b0});
    vecs.push_back('{5'd31, 5'd31, 5'd1,  5'd0,  1'b0, 1'b0});
    vecs.push_back('{5'd30, 5'd7,  5'd4,  5'd2,  1'b0, 1'b0});
    vecs.push_back('{5'd5,  5'd9,  5'd0,  5'd5,  1'b0, 1'b0});
    vecs.push_back('{5'd31, 5'd2,  5'd15, 5'd1,  1'b0, 1'b0});
    vecs.push_back('{5'd0,  5'd0,  5'd31, 5'd0,  1'b1, 1'b0});
    for (int i = 0; i < 6; i++) begin
      v.x   = W'($urandom_range(0, 31));
      v.y   = W'($urandom_range(1, 31));
      v.q   = v.x / v.y;
      v.r   = v.x % v.y;
      v.dbz = 1'b0;
      v.ovf = 1'b0;
      vecs.push_back(v);
    end
`endif

    // Reset state.
    rst_n = 1'b0;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstQ", int'(Q), 0);
    checkOutput("rstR", int'(R), 0);
    checkOutput("rstDbz", int'(DivByZero), 0);
    checkOutput("rstOvf", int'(Overflow), 0);
    rst_n = 1'b1;

    // Table-driven operations.
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Held start with changing operands during RUN must be ignored.
    @(negedge clk);
    X     = 5'd31;
    Y     = 5'd1;
    start = 1'b1;
    v     = '{5'd31, 5'd1, 5'd31, 5'd0, 1'b0, 1'b0};
    sb.push_back(v);
    @(posedge clk);
    #1;
    X = 5'd9;
    Y = 5'd3;
    waitDone(lat, nBusy);
    start = 1'b0;
    if (lat != 0) checkOutput("heldStartLatency", lat, W + 1);
    stray = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checkOutput("ignoredRequest", stray, 0);

    // Reset at the third RUN edge aborts the operation without a done.
    @(negedge clk);
    X     = 5'd20;
    Y     = 5'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDone", int'(done), 0);
    checkOutput("abortQ", int'(Q), 0);
    checkOutput("abortR", int'(R), 0);
    checkOutput("abortDbz", int'(DivByZero), 0);
    checkOutput("abortOvf", int'(Overflow), 0);
    rst_n = 1'b1;
`ifdef SIGNED_DIV_EN
    v = '{5'd20, 5'd3, 5'd28, 5'd0, 1'b0, 1'b0};
`else
    v = '{5'd20, 5'd3, 5'd6, 5'd2, 1'b0, 1'b0};
`endif
    applyStimulus(v);

    repeat (3) @(negedge clk);
    checkOutput("scoreboardEmpty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
